// File: rtl/mem_subword_pkg.sv
// mem_subword_pkg: shared definitions for the sub-word memory controller.
//   - request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
//   - controller FSM state type with fixed legacy encodings
//   - default access timeout (TIMEOUT_CYC_DEF)
//   - size_misaligned(): accept-time legality check of size vs. address
package mem_subword_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int unsigned TIMEOUT_CYC_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // 1 when the request can never reach memory: illegal size code,
   // odd halfword address or non word-aligned word address.
   function automatic logic size_misaligned(input logic [1:0] size,
                                            input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load-lane extraction and extension.
// Ports:
//   rdata     in  32  raw memory word
//   lane      in  2   byte offset of the access (addr[1:0])
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed in  1   1 = sign-extend, 0 = zero-extend (ignored for words)
//   data32    out 32  right-justified, extended load data
module mem_load_ext
   import mem_subword_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] data32
);

   logic [15:0] sel;

   always_comb begin
      // Shift the addressed lane down to bit 0; only the low half is needed.
      sel    = 16'(rdata >> {lane, 3'b000});
      data32 = rdata;
      case (size)
         SZ_BYTE: data32 = {{24{is_signed & sel[7]}},  sel[7:0]};
         SZ_HALF: data32 = {{16{is_signed & sel[15]}}, sel[15:0]};
         default: data32 = rdata;
      endcase
   end

endmodule

// File: rtl/mem_subword_ctrl.sv
// mem_subword_ctrl: single-outstanding byte/half/word load-store controller
// sitting between a valid/ready request port and a word-wide memory port.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata
//   rsp_valid, rsp_rdata, rsp_err      one-cycle response strobe
//   mem_en, mem_be, mem_addr, mem_wdata, mem_we, mem_ready, mem_rdata
// Parameter TIMEOUT_CYC (1..1023): ACCESS cycles allowed before abort.
// Optional build macro MEM_SUBWORD_CTRL_TIMEOUT_EN adds the access timeout;
// without it the controller waits for mem_ready indefinitely.
module mem_subword_ctrl
   import mem_subword_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_en,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
      $error("mem_subword_ctrl: TIMEOUT_CYC out of range 1..1023");
   end

   state_t      state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] rsp_data_q;
   logic        rsp_err_q;
   logic [31:0] load_data;
   logic        in_access;
   logic [3:0]  be;
   logic [31:0] wdata_rep;

`ifdef MEM_SUBWORD_CTRL_TIMEOUT_EN
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
   logic [9:0] to_cnt;
`endif

   mem_load_ext u_load_ext (
      .rdata     (mem_rdata),
      .lane      (r_addr[1:0]),
      .size      (r_size),
      .is_signed (r_signed),
      .data32    (load_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_signed   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
`ifdef MEM_SUBWORD_CTRL_TIMEOUT_EN
         to_cnt     <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_signed   <= req_signed;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  rsp_data_q <= '0;
`ifdef MEM_SUBWORD_CTRL_TIMEOUT_EN
                  to_cnt     <= '0;
`endif
                  // Illegal requests skip the memory cycle entirely.
                  if (size_misaligned(req_size, req_addr[1:0])) begin
                     rsp_err_q <= 1'b1;
                     state     <= ST_RESP;
                  end else begin
                     rsp_err_q <= 1'b0;
                     state     <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  rsp_data_q <= r_we ? '0 : load_data;
                  rsp_err_q  <= 1'b0;
                  state      <= ST_RESP;
               end
`ifdef MEM_SUBWORD_CTRL_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  to_cnt <= to_cnt + 10'd1;
               end
`endif
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      be = 4'b0000;
      case (r_size)
         SZ_BYTE: be = 4'b0001 << r_addr[1:0];
         SZ_HALF: be = 4'b0011 << r_addr[1:0];
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      wdata_rep = r_wdata;
      case (r_size)
         SZ_BYTE: wdata_rep = {4{r_wdata[7:0]}};
         SZ_HALF: wdata_rep = {2{r_wdata[15:0]}};
         default: wdata_rep = r_wdata;
      endcase
   end

   // Memory-side outputs come straight from the request registers, so they
   // cannot change while ACCESS waits for mem_ready.
   assign in_access = (state == ST_ACCESS);
   assign req_ready = (state == ST_IDLE);
   assign mem_en    = in_access;
   assign mem_we    = in_access & r_we;
   assign mem_be    = in_access ? be : 4'b0000;
   assign mem_addr  = in_access ? {r_addr[31:2], 2'b00} : '0;
   assign mem_wdata = in_access ? wdata_rep : '0;
   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = (state == ST_RESP) ? rsp_data_q : '0;
   assign rsp_err   = (state == ST_RESP) & rsp_err_q;

endmodule

// File: doc/mem_subword_ctrl.md
MEM_SUBWORD_CTRL -- requirements
Module: mem_subword_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum ACCESS-state cycles before abort (range 1..1023).
REQ-002 SHALL have these ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  reset; synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  load extension: 1 sign, 0 zero.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or timeout; valid with rsp_valid.
- mem_en  out  1  memory access active.
- mem_be  out  4  byte enables, little-endian lanes.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_we  out  1  memory write.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  32  memory read word, valid when mem_ready is high.

Function
REQ-003 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on an error detected at accept.
REQ-004 IDLE: req_ready=1 and all other outputs 0; on accept, SHALL register we, size, signed, addr and wdata.
REQ-005 At accept, SHALL flag an error for: size 11; half with addr[0]=1; word with addr[1:0]!=0. On error SHALL issue no memory cycle.
REQ-006 ACCESS: mem_en=1; mem_be, mem_addr, mem_wdata and mem_we SHALL be held stable until the cycle in which mem_ready=1. req_ready SHALL be 0 in ACCESS and RESP.
REQ-007 mem_be SHALL be: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-008 mem_wdata SHALL be: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-009 Load data SHALL be taken from lane addr[1:0] of mem_rdata and sign- or zero-extended to 32 bits per req_signed; word loads ignore req_signed. Data SHALL be registered in the mem_ready cycle.
REQ-010 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-011 Latency: accept at cycle t with mem_ready=1 at t+1 gives rsp_valid at t+2. Error path: rsp_valid at t+1.
REQ-012 mem_ready received outside ACCESS SHALL be ignored.
REQ-013 A new request SHALL be accepted no earlier than the cycle after RESP; there is no back-to-back overlap.

Reset
REQ-014 While reset=0 at a clk edge, SHALL enter IDLE with all outputs 0 except req_ready=1, and clear the timeout counter.
REQ-015 Reset in ACCESS or RESP SHALL abort the transaction: mem_en=0 from the next cycle and no rsp_valid for the aborted request.

Configuration
REQ-016 Macro MEM_SUBWORD_CTRL_TIMEOUT_EN defined: a counter SHALL run in ACCESS. If mem_ready is still 0 after TIMEOUT_CYC cycles, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0, and drop mem_en.
REQ-017 Macro undefined: SHALL wait in ACCESS indefinitely; there SHALL be no counter logic, and rsp_err SHALL come only from REQ-005.

Structure
REQ-018 The shared package mem_subword_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the default TIMEOUT_CYC.
REQ-019 Lane extraction and extension SHALL be in the combinational sub-module mem_load_ext, with inputs rdata, lane, size and signed and output data32.

Verification
REQ-020 sb addr 0x00000013, wdata 0x000000A5, mem_ready at t+1 -> mem_be 4'b1000, mem_addr 0x00000010, mem_wdata 0xA5A5A5A5, rsp_valid at t+2, rsp_err 0.
REQ-021 lb addr 0x1 signed, mem_rdata 0x00008000 -> rsp_rdata 0xFFFFFF80; the same load with lbu -> 0x00000080.
REQ-022 lh addr 0x2 signed, mem_rdata 0x80010000 -> rsp_rdata 0xFFFF8001; lh addr 0x3 -> mem_en never asserted, rsp_err 1 at t+1.
REQ-023 sw addr 0x4, mem_ready held 0 for 5 cycles -> mem_* outputs stable for all cycles, rsp_valid 1 cycle after mem_ready; with the macro defined, TIMEOUT_CYC=4 and mem_ready stuck 0 -> rsp_err 1, rsp_rdata 0.
REQ-024 reset=0 pulsed during ACCESS -> next cycle mem_en 0 and req_ready 1; a later mem_ready produces no rsp_valid.
REQ-025 req_size 11 -> rsp_err 1 and no memory cycle; stray mem_ready in IDLE -> no state change.
